// File: rtl/k6502_seq_pkg.sv
// Shared definitions for the k6502 sequencer: control-word layout, address
// modes, register selects and the one-hot cycle encodings.
package k6502_seq_pkg;

  localparam int unsigned X_BITS     = 13;
  localparam int unsigned CYCLE_BITS = 6;

  // Bit positions within the microcode control word, MSB first
  localparam int unsigned X_PC_UPDATE  = 12;
  localparam int unsigned X_REG_W      = 11;
  localparam int unsigned X_REG_R      = 10;
  localparam int unsigned X_REG_SEL_HI = 9;
  localparam int unsigned X_REG_SEL_LO = 8;
  localparam int unsigned X_ADDR_MODE  = 7;
  localparam int unsigned X_DL_LATCH_H = 6;
  localparam int unsigned X_DL_LATCH_L = 5;
  localparam int unsigned X_PC_LATCH_H = 4;
  localparam int unsigned X_PC_LATCH_L = 3;
  localparam int unsigned X_INC_DL     = 2;
  localparam int unsigned X_INC_PC     = 1;
  localparam int unsigned X_SYNC       = 0;

  localparam logic ADDR_MODE_PC = 1'b0;
  localparam logic ADDR_MODE_DL = 1'b1;

  localparam logic [1:0] R_N = 2'd0;
  localparam logic [1:0] R_A = 2'd1;
  localparam logic [1:0] R_X = 2'd2;
  localparam logic [1:0] R_Y = 2'd3;

  localparam logic [CYCLE_BITS-1:0] C_N = 6'b000000;
  localparam logic [CYCLE_BITS-1:0] C_0 = 6'b000001;
  localparam logic [CYCLE_BITS-1:0] C_1 = 6'b000010;
  localparam logic [CYCLE_BITS-1:0] C_2 = 6'b000100;
  localparam logic [CYCLE_BITS-1:0] C_3 = 6'b001000;
  localparam logic [CYCLE_BITS-1:0] C_4 = 6'b010000;
  localparam logic [CYCLE_BITS-1:0] C_5 = 6'b100000;

  // Decoded control word
  typedef struct packed {
    logic       pc_update;
    logic       reg_w;
    logic       reg_r;
    logic [1:0] reg_sel;
    logic       addr_mode;
    logic       dl_latch_h;
    logic       dl_latch_l;
    logic       pc_latch_h;
    logic       pc_latch_l;
    logic       inc_dl;
    logic       inc_pc;
    logic       sync;
  } ctrl_t;

  // Split a raw control word into named fields
  function automatic ctrl_t decode_x(input logic [X_BITS-1:0] x);
    ctrl_t c;
    c.pc_update  = x[X_PC_UPDATE];
    c.reg_w      = x[X_REG_W];
    c.reg_r      = x[X_REG_R];
    c.reg_sel    = x[X_REG_SEL_HI:X_REG_SEL_LO];
    c.addr_mode  = x[X_ADDR_MODE];
    c.dl_latch_h = x[X_DL_LATCH_H];
    c.dl_latch_l = x[X_DL_LATCH_L];
    c.pc_latch_h = x[X_PC_LATCH_H];
    c.pc_latch_l = x[X_PC_LATCH_L];
    c.inc_dl     = x[X_INC_DL];
    c.inc_pc     = x[X_INC_PC];
    c.sync       = x[X_SYNC];
    return c;
  endfunction

endpackage

// File: rtl/k6502_seq_pc.sv
// Program counter, PC byte temporaries and the data-latch address pair.
module k6502_pc
  import k6502_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  ctrl_t       ctrl,
  input  logic [7:0]  data_in,
  output logic [15:0] pc,
  output logic [15:0] dl
);

  logic [7:0]  pcl_t;
  logic [7:0]  pch_t;
  logic [15:0] dl_lat;
  logic [15:0] dl_next;
  logic [15:0] pc_load;

  // Same-cycle latched bytes are bypassed into the DL increment and PC load
  always_comb begin
    dl_lat  = {ctrl.dl_latch_h ? data_in : dl[15:8],
               ctrl.dl_latch_l ? data_in : dl[7:0]};
    dl_next = ctrl.inc_dl ? dl_lat + 16'd1 : dl_lat;
    pc_load = {ctrl.pc_latch_h ? data_in : pch_t,
               ctrl.pc_latch_l ? data_in : pcl_t};
  end

  // Address registers; reset wins, otherwise update only when enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      dl    <= 16'h0000;
      pcl_t <= 8'h00;
      pch_t <= 8'h00;
    end else if (en) begin
      if (ctrl.pc_latch_l) pcl_t <= data_in;
      if (ctrl.pc_latch_h) pch_t <= data_in;
      dl <= dl_next;
      if (ctrl.pc_update)   pc <= pc_load;
      else if (ctrl.inc_pc) pc <= pc + 16'd1;
    end
  end

endmodule

// File: rtl/k6502_seq.sv
// Microcoded instruction sequencer: fetch/execute FSM, one-hot cycle counter,
// address mux and register strobes driven by an external control-word ROM.
module k6502_seq
  import k6502_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [X_BITS-1:0]     x,
  output logic [7:0]            ir,
  output logic [CYCLE_BITS-1:0] cycle,
  output logic [15:0]           addr,
  output logic                  mem_rd,
  input  logic [7:0]            data_in,
  input  logic                  mem_ready,
  output logic [15:0]           pc,
  output logic                  reg_we,
  output logic                  reg_re,
  output logic [1:0]            reg_sel,
  output logic [7:0]            reg_wdata,
  output logic                  fault
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t      state;
  ctrl_t       ctrl;
  logic        honour;
  logic [15:0] dl;

  // Control word is ignored during opcode fetch
  always_comb begin
    ctrl   = decode_x(x);
    honour = (state != S_FETCH);
  end

  // Memory address and register strobes follow state and control word
  always_comb begin
    addr      = (!honour || ctrl.addr_mode == ADDR_MODE_PC) ? pc : dl;
    mem_rd    = (state != S_RESET);
    reg_we    = honour & ctrl.reg_w & mem_ready & ~reset;
    reg_re    = honour & ctrl.reg_r & mem_ready & ~reset;
    reg_sel   = ctrl.reg_sel;
    reg_wdata = data_in;
  end

  k6502_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .en      (honour & mem_ready),
    .ctrl    (ctrl),
    .data_in (data_in),
    .pc      (pc),
    .dl      (dl)
  );

  // Sequencer FSM with opcode, cycle and overrun flag; frozen while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      ir    <= 8'h00;
      cycle <= C_N;
      fault <= 1'b0;
    end else if (mem_ready) begin
      case (state)
        S_RESET: begin
          if (ctrl.sync) state <= S_FETCH;
        end
        S_FETCH: begin
          ir    <= data_in;
          cycle <= C_0;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (ctrl.sync) begin
            cycle <= C_N;
            state <= S_FETCH;
          end else if (cycle == C_5) begin
            fault <= 1'b1;
            cycle <= C_N;
            state <= S_FETCH;
          end else begin
            cycle <= {cycle[CYCLE_BITS-2:0], 1'b0};
          end
        end
        default: begin
          cycle <= C_N;
          state <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k6502_seq.sv
// Testbench for k6502_seq: small program memory plus a microcode ROM model,
// a cycle-by-cycle vector table and directed corner-case sequences.
module tb_k6502_seq;
  import k6502_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic [12:0] x;
  logic [7:0]  ir;
  logic [5:0]  cycle;
  logic [15:0] addr;
  logic        mem_rd;
  logic [7:0]  data_in;
  logic        mem_ready;
  logic [15:0] pc;
  logic        reg_we;
  logic        reg_re;
  logic [1:0]  reg_sel;
  logic [7:0]  reg_wdata;
  logic        fault;

  logic [7:0]  mem [0:65535];
  logic        x_ovr_en;
  logic [12:0] x_ovr;
  logic        din_ovr_en;
  logic [7:0]  din_ovr;

  int errors = 0;
  int checks = 0;

  k6502_seq #(.RESET_PC(16'h0200)) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .ir        (ir),
    .cycle     (cycle),
    .addr      (addr),
    .mem_rd    (mem_rd),
    .data_in   (data_in),
    .mem_ready (mem_ready),
    .pc        (pc),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_sel   (reg_sel),
    .reg_wdata (reg_wdata),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference microcode: A9 LDA #, 4C JMP abs, AD LDA abs, EA NOP (with REG_R)
  function automatic logic [12:0] rom(input logic [7:0] op, input logic [5:0] cyc);
    if (cyc == 6'b000000) return 13'h0001;
    case (op)
      8'hA9: return (cyc == 6'b000001) ? 13'h0002 :
                    (cyc == 6'b000010) ? 13'h0903 : 13'h0000;
      8'h4C: return (cyc == 6'b000001) ? 13'h0002 :
                    (cyc == 6'b000010) ? 13'h000A :
                    (cyc == 6'b000100) ? 13'h1011 : 13'h0000;
      8'hAD: return (cyc == 6'b000001) ? 13'h0002 :
                    (cyc == 6'b000010) ? 13'h0022 :
                    (cyc == 6'b000100) ? 13'h0042 :
                    (cyc == 6'b001000) ? 13'h0981 : 13'h0000;
      8'hEA: return (cyc == 6'b000001) ? 13'h0403 : 13'h0000;
      default: return 13'h0000;
    endcase
  endfunction

  assign x       = x_ovr_en ? x_ovr : rom(ir, cycle);
  assign data_in = din_ovr_en ? din_ovr : mem[addr];

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [7:0]  ir;
    logic [5:0]  cyc;
    logic        we;
    logic        rd;
    logic [7:0]  wdata;
  } vec_t;

  vec_t tv [26];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] exp_cyc;
    reset      = 1'b1;
    mem_ready  = 1'b1;
    x_ovr_en   = 1'b0;
    x_ovr      = 13'h0000;
    din_ovr_en = 1'b0;
    din_ovr    = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h5A;
    mem[16'h0202] = 8'h4C; mem[16'h0203] = 8'h34; mem[16'h0204] = 8'h12;
    mem[16'h1234] = 8'hAD; mem[16'h1235] = 8'h78; mem[16'h1236] = 8'h56;
    mem[16'h5678] = 8'hC3;

    //            rst   rdy   addr      pc        ir     cyc       we    rd    wdata
    tv[0]  = '{1'b1, 1'b1, 16'h0200, 16'h0200, 8'h00, 6'b000000, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b0, 1'b1, 16'h0200, 16'h0200, 8'h00, 6'b000000, 1'b0, 1'b0, 8'h00};
    tv[2]  = '{1'b0, 1'b1, 16'h0200, 16'h0200, 8'h00, 6'b000000, 1'b0, 1'b1, 8'h00};
    tv[3]  = '{1'b0, 1'b1, 16'h0200, 16'h0200, 8'hA9, 6'b000001, 1'b0, 1'b1, 8'h00};
    tv[4]  = '{1'b0, 1'b1, 16'h0201, 16'h0201, 8'hA9, 6'b000010, 1'b1, 1'b1, 8'h5A};
    tv[5]  = '{1'b0, 1'b1, 16'h0202, 16'h0202, 8'hA9, 6'b000000, 1'b0, 1'b1, 8'h00};
    tv[6]  = '{1'b0, 1'b1, 16'h0202, 16'h0202, 8'h4C, 6'b000001, 1'b0, 1'b1, 8'h00};
    tv[7]  = '{1'b0, 1'b1, 16'h0203, 16'h0203, 8'h4C, 6'b000010, 1'b0, 1'b1, 8'h00};
    tv[8]  = '{1'b0, 1'b1, 16'h0204, 16'h0204, 8'h4C, 6'b000100, 1'b0, 1'b1, 8'h00};
    tv[9]  = '{1'b0, 1'b1, 16'h1234, 16'h1234, 8'h4C, 6'b000000, 1'b0, 1'b1, 8'h00};
    tv[10] = '{1'b0, 1'b1, 16'h1234, 16'h1234, 8'hAD, 6'b000001, 1'b0, 1'b1, 8'h00};
    tv[11] = '{1'b0, 1'b1, 16'h1235, 16'h1235, 8'hAD, 6'b000010, 1'b0, 1'b1, 8'h00};
    tv[12] = '{1'b0, 1'b1, 16'h1236, 16'h1236, 8'hAD, 6'b000100, 1'b0, 1'b1, 8'h00};
    tv[13] = '{1'b0, 1'b1, 16'h5678, 16'h1237, 8'hAD, 6'b001000, 1'b1, 1'b1, 8'hC3};
    tv[14] = '{1'b1, 1'b1, 16'h1237, 16'h1237, 8'hAD, 6'b000000, 1'b0, 1'b1, 8'h00};
    tv[15] = '{1'b0, 1'b1, 16'h0200, 16'h0200, 8'h00, 6'b000000, 1'b0, 1'b0, 8'h00};
    tv[16] = '{1'b0, 1'b1, 16'h0200, 16'h0200, 8'h00, 6'b000000, 1'b0, 1'b1, 8'h00};
    tv[17] = '{1'b0, 1'b1, 16'h0200, 16'h0200, 8'hA9, 6'b000001, 1'b0, 1'b1, 8'h00};
    tv[18] = '{1'b0, 1'b0, 16'h0201, 16'h0201, 8'hA9, 6'b000010, 1'b0, 1'b1, 8'h00};
    tv[19] = '{1'b0, 1'b0, 16'h0201, 16'h0201, 8'hA9, 6'b000010, 1'b0, 1'b1, 8'h00};
    tv[20] = '{1'b0, 1'b0, 16'h0201, 16'h0201, 8'hA9, 6'b000010, 1'b0, 1'b1, 8'h00};
    tv[21] = '{1'b0, 1'b1, 16'h0201, 16'h0201, 8'hA9, 6'b000010, 1'b1, 1'b1, 8'h5A};
    tv[22] = '{1'b0, 1'b0, 16'h0202, 16'h0202, 8'hA9, 6'b000000, 1'b0, 1'b1, 8'h00};
    tv[23] = '{1'b0, 1'b1, 16'h0202, 16'h0202, 8'hA9, 6'b000000, 1'b0, 1'b1, 8'h00};
    tv[24] = '{1'b1, 1'b0, 16'h0202, 16'h0202, 8'h4C, 6'b000001, 1'b0, 1'b1, 8'h00};
    tv[25] = '{1'b0, 1'b1, 16'h0200, 16'h0200, 8'h00, 6'b000000, 1'b0, 1'b0, 8'h00};

    tick();
    tick();

    // Cycle-by-cycle program run: LDA #, JMP, LDA abs, stalls, resets
    for (int i = 0; i < 26; i++) begin
      reset     = tv[i].rst;
      mem_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d addr", i),  addr,             tv[i].addr);
      chk($sformatf("v%0d pc", i),    pc,               tv[i].pc);
      chk($sformatf("v%0d ir", i),    16'(ir),          16'(tv[i].ir));
      chk($sformatf("v%0d cycle", i), 16'(cycle),       16'(tv[i].cyc));
      chk($sformatf("v%0d reg_we", i), 16'(reg_we),     16'(tv[i].we));
      chk($sformatf("v%0d mem_rd", i), 16'(mem_rd),     16'(tv[i].rd));
      if (tv[i].we) begin
        chk($sformatf("v%0d reg_wdata", i), 16'(reg_wdata), 16'(tv[i].wdata));
        chk($sformatf("v%0d reg_sel", i),   16'(reg_sel),   16'(R_A));
      end
      @(posedge clk);
      #1;
    end
    reset     = 1'b0;
    mem_ready = 1'b1;

    // Reset during JMP C_1: no PC latch/increment survives
    mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
    do_reset();
    tick(); tick(); tick();
    chk("jmp c1 cycle", 16'(cycle), 16'(C_1));
    chk("jmp c1 addr", addr, 16'h0201);
    reset = 1'b1;
    tick();
    chk("jmp rst cycle", 16'(cycle), 16'h0000);
    chk("jmp rst ir", 16'(ir), 16'h0000);
    chk("jmp rst pc", pc, 16'h0200);
    chk("jmp rst mem_rd", 16'(mem_rd), 16'h0000);
    reset = 1'b0;

    // Reset during LDA C_1: register write suppressed, no PC increment
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h5A;
    do_reset();
    tick(); tick(); tick();
    chk("lda c1 reg_we", 16'(reg_we), 16'h0001);
    reset = 1'b1;
    #1;
    chk("lda rst reg_we", 16'(reg_we), 16'h0000);
    tick();
    chk("lda rst pc", pc, 16'h0200);
    reset = 1'b0;

    // Overrun: NOP then opcode FF with empty microcode
    mem[16'h0200] = 8'hEA; mem[16'h0201] = 8'hFF;
    do_reset();
    tick();
    chk("nop fetch addr", addr, 16'h0200);
    tick();
    chk("nop reg_re", 16'(reg_re), 16'h0001);
    chk("nop reg_we", 16'(reg_we), 16'h0000);
    tick();
    chk("ovr fetch addr", addr, 16'h0201);
    tick();
    chk("ovr ir", 16'(ir), 16'h00FF);
    for (int k = 0; k < 6; k++) begin
      exp_cyc = 6'(1 << k);
      chk($sformatf("ovr cycle %0d", k), 16'(cycle), 16'(exp_cyc));
      chk($sformatf("ovr fault %0d", k), 16'(fault), 16'h0000);
      tick();
    end
    chk("ovr end cycle", 16'(cycle), 16'h0000);
    chk("ovr end fault", 16'(fault), 16'h0001);
    chk("ovr end addr", addr, 16'h0201);
    chk("ovr end pc", pc, 16'h0201);
    tick();
    chk("ovr sticky fault", 16'(fault), 16'h0001);
    do_reset();
    chk("ovr reset fault", 16'(fault), 16'h0000);

    // Direct-driven control words in the RESET state
    x_ovr_en   = 1'b1;
    din_ovr_en = 1'b1;
    x_ovr = 13'h0008; din_ovr = 8'hCD;
    tick();
    chk("dir latch pc", pc, 16'h0200);
    chk("dir stay cycle", 16'(cycle), 16'h0000);
    x_ovr = 13'h1012; din_ovr = 8'hAB;
    tick();
    chk("dir pc update", pc, 16'hABCD);
    x_ovr = 13'h1018; din_ovr = 8'hFF;
    tick();
    chk("dir pc ffff", pc, 16'hFFFF);
    x_ovr = 13'h0002; mem_ready = 1'b0;
    tick();
    chk("dir stall pc", pc, 16'hFFFF);
    mem_ready = 1'b1;
    tick();
    chk("dir pc wrap", pc, 16'h0000);
    x_ovr = 13'h00E0; din_ovr = 8'hFF;
    tick();
    x_ovr = 13'h0080;
    #1;
    chk("dir dl ffff", addr, 16'hFFFF);
    x_ovr = 13'h0084;
    tick();
    x_ovr = 13'h0080;
    #1;
    chk("dir dl wrap", addr, 16'h0000);
    x_ovr = 13'h0024; din_ovr = 8'h12;
    tick();
    x_ovr = 13'h0080;
    #1;
    chk("dir dl latch inc", addr, 16'h0013);
    x_ovr = 13'h0F00; din_ovr = 8'h77;
    #1;
    chk("dir reg_we", 16'(reg_we), 16'h0001);
    chk("dir reg_re", 16'(reg_re), 16'h0001);
    chk("dir reg_sel", 16'(reg_sel), 16'(R_Y));
    chk("dir reg_wdata", 16'(reg_wdata), 16'h0077);
    mem_ready = 1'b0;
    #1;
    chk("dir stall reg_we", 16'(reg_we), 16'h0000);
    chk("dir stall reg_re", 16'(reg_re), 16'h0000);
    mem_ready = 1'b1;
    x_ovr = 13'h0001;
    tick();
    x_ovr = 13'h1099; din_ovr = 8'h55;
    #1;
    chk("fetch ignores x addr", addr, 16'h0000);
    chk("fetch reg_we", 16'(reg_we), 16'h0000);
    tick();
    chk("fetch ignores x pc", pc, 16'h0000);
    chk("fetch ir", 16'(ir), 16'h0055);
    chk("fetch cycle", 16'(cycle), 16'(C_0));
    x_ovr_en   = 1'b0;
    din_ovr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
